// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first, mid-bit sampling with a free-running per-bit counter.
// Presents the last correctly framed byte and pulses rx_done_o / frame_err_o per frame.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] uart_data_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned BaudCnt = CLK_FREQ / BAUD;
  localparam int unsigned HalfCnt = BaudCnt / 2 - 1;
  localparam int unsigned CntW    = (BaudCnt > 1) ? $clog2(BaudCnt) : 1;

  localparam logic [CntW-1:0] CntMax  = CntW'(BaudCnt - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HalfCnt);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic            rx_s1_q, rx_s2_q, rx_d_q;
  logic            fall;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic [7:0]      uart_data_q;
  logic            rx_done_q, frame_err_q;

  // Synchronizer and history flops reset high so reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rx_d_q  <= rx_s2_q;
    end
  end

  assign fall = rx_d_q & ~rx_s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      uart_data_q <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (fall) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf && rx_s2_q) begin
            // Start bit high at mid-bit: treat as a glitch.
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q   <= StData;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntHalf) begin
            shreg_q[bit_idx_q] <= rx_s2_q;
          end
          if (cnt_q == CntMax) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (cnt_q == CntHalf) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            if (rx_s2_q) begin
              uart_data_q <= shreg_q;
              rx_done_q   <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign uart_data_o = uart_data_q;
  assign rx_done_o   = rx_done_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (HALF = 7).
// A negedge monitor records strobe counts and timing; the stimulus compares against hand-derived values.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] uart_data;
  logic       rx_done, frame_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int done_cnt = 0, done_hi = 0, last_done = -1;
  int err_cnt = 0, err_hi = 0, last_err = -1;
  int busy_cyc = 0, both_hi = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ(16),
    .BAUD    (1)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_i       (rx),
    .uart_data_o(uart_data),
    .rx_done_o  (rx_done),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_hi = done_hi + 1;
      if (!done_prev) begin
        done_cnt  = done_cnt + 1;
        last_done = cyc;
      end
    end
    if (frame_err) begin
      err_hi = err_hi + 1;
      if (!err_prev) begin
        err_cnt  = err_cnt + 1;
        last_err = cyc;
      end
    end
    if (busy) busy_cyc = busy_cyc + 1;
    if (rx_done && frame_err) both_hi = both_hi + 1;
    done_prev = rx_done;
    err_prev  = frame_err;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one full frame from a negedge; start returns the cycle count when the start bit began.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int start);
    start = cyc;
    rx = 1'b0;
    wait_cycles(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(16);
    end
    rx = stop;
    wait_cycles(16);
  endtask

  int s, s2, d0, e0, b0, d1;
  logic [7:0] v77;

  initial begin
    // Reset
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_data", int'(uart_data), 0);
    check_eq("rst_done", int'(rx_done), 0);
    check_eq("rst_err", int'(frame_err), 0);
    check_eq("rst_busy", int'(busy), 0);
    wait_cycles(200);
    check_eq("idle_done", done_cnt, 0);
    check_eq("idle_err", err_cnt, 0);
    check_eq("idle_busy", busy_cyc, 0);

    // Single byte 0xA5: strobe at D+153 = start+155
    send_frame(8'hA5, 1'b1, s);
    check_eq("a5_count", done_cnt, 1);
    check_eq("a5_time", last_done, s + 155);
    check_eq("a5_data", int'(uart_data), 32'hA5);
    check_eq("a5_hi_digit", int'(uart_data[7:4]), 10);
    check_eq("a5_lo_digit", int'(uart_data[3:0]), 5);
    wait_cycles(20);

    // Back-to-back 0x3C then 0xFF
    send_frame(8'h3C, 1'b1, s);
    d1 = last_done;
    check_eq("b2b_first_time", d1, s + 155);
    check_eq("b2b_first_data", int'(uart_data), 32'h3C);
    send_frame(8'hFF, 1'b1, s2);
    check_eq("b2b_count", done_cnt, 3);
    check_eq("b2b_spacing", last_done - d1, 160);
    check_eq("b2b_second_data", int'(uart_data), 32'hFF);
    wait_cycles(20);

    // Glitch: 4-cycle low pulse
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cyc;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(30);
    check_eq("glitch_busy_cycles", busy_cyc - b0, 8);
    check_eq("glitch_done", done_cnt - d0, 0);
    check_eq("glitch_err", err_cnt - e0, 0);
    check_eq("glitch_idle", int'(busy), 0);

    // Framing error: 0x12 with stop low, line kept low afterwards
    send_frame(8'h12, 1'b0, s);
    check_eq("ferr_count", err_cnt - e0, 1);
    check_eq("ferr_time", last_err, s + 155);
    check_eq("ferr_no_done", done_cnt - d0, 0);
    check_eq("ferr_data_kept", int'(uart_data), 32'hFF);
    b0 = busy_cyc;
    wait_cycles(100);
    check_eq("ferr_low_no_start", busy_cyc - b0, 0);
    rx = 1'b1;
    wait_cycles(40);
    check_eq("ferr_still_idle", int'(busy), 0);

    // Reset during data bit 4 of 0x77, then a clean 0x81
    d0 = done_cnt;
    e0 = err_cnt;
    v77 = 8'h77;
    rx = 1'b0;
    wait_cycles(16);
    for (int i = 0; i < 4; i++) begin
      rx = v77[i];
      wait_cycles(16);
    end
    rx = v77[4];
    wait_cycles(8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx    = 1'b1;
    check_eq("mid_rst_data", int'(uart_data), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    wait_cycles(300);
    check_eq("mid_rst_no_done", done_cnt - d0, 0);
    check_eq("mid_rst_no_err", err_cnt - e0, 0);
    send_frame(8'h81, 1'b1, s);
    check_eq("post_rst_count", done_cnt - d0, 1);
    check_eq("post_rst_time", last_done, s + 155);
    check_eq("post_rst_data", int'(uart_data), 32'h81);
    wait_cycles(20);

    // Whole-run strobe shape
    check_eq("done_pulses", done_cnt, 4);
    check_eq("done_width", done_hi, 4);
    check_eq("err_pulses", err_cnt, 1);
    check_eq("err_width", err_hi, 1);
    check_eq("never_both", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first. It recovers bytes from the `rx` pin and presents the last good byte on `uart_data`. That bus feeds the seven-segment display driver, which shows the byte as two hex digits. Each accepted byte raises a one-cycle `rx_done` strobe, and a bad stop bit raises `frame_err`.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- Derived `BAUD_CNT = CLK_FREQ/BAUD` (integer divide; 5208 at defaults). `BAUD_CNT` must be ≥ 4.
- Derived `HALF = BAUD_CNT/2 - 1` (2603 at defaults).
- `clk` input, 1 bit: system clock. All logic runs in this single clock domain.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `rx` input, 1 bit: serial line. Asynchronous to `clk`; idles high.
- `uart_data` output, 8 bits: last correctly framed byte. Registered.
- `rx_done` output, 1 bit: one-cycle pulse when `uart_data` is updated.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit samples low.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- Input conditioning:
  - `rx` passes through two synchronizer flops (`rx_s1`, `rx_s2`), then one history flop `rx_d`.
  - All three reset to 1, so reset never creates a false edge.
  - `fall = rx_d & ~rx_s2`.
- Bit counter `cnt` (width ≥ clog2(`BAUD_CNT`)):
  - Counts 0..`BAUD_CNT-1` in every non-IDLE state.
  - Wraps to 0 at `BAUD_CNT-1`.
  - Forced to 0 in IDLE and on every state change.
- Bit index `bit_idx` (3 bits): counts data bits 0..7.
- Shift register `shreg` (8 bits): assembles the byte.
- State machine, one-hot or encoded:
  - IDLE: if `fall`, go to START with `cnt`=0. Otherwise stay.
  - START: at `cnt==HALF`, if `rx_s2` is 1, treat it as a glitch and return to IDLE with no outputs. At `cnt==BAUD_CNT-1`, go to DATA with `bit_idx`=0.
  - DATA: at `cnt==HALF`, set `shreg[bit_idx] <= rx_s2` (LSB first). At `cnt==BAUD_CNT-1`, increment `bit_idx`; after bit 7 go to STOP.
  - STOP: at `cnt==HALF`, sample `rx_s2` and return to IDLE immediately. The remaining half stop bit is not waited out, so a back-to-back start edge is caught.
    - If the sample is 1, `uart_data <= shreg` and `rx_done` pulses.
    - If the sample is 0, `frame_err` pulses and `uart_data` is unchanged.
- A low line after a framing error does not start a new frame until `rx` has returned high and fallen again (edge detect only).
- `uart_data` changes only in the cycle `rx_done` is high. It holds indefinitely otherwise.
- `rx_done` and `frame_err` are never high together.

## Timing
- Reset values: `uart_data`=8'h00, `rx_done`=0, `frame_err`=0, `busy`=0, state=IDLE, `cnt`=0, `bit_idx`=0, `shreg`=0.
- Reset taken mid-frame aborts the frame with no strobe. The next frame needs a fresh falling edge after `rst_n` returns high.
- Pin to `fall`: `rx` low sampled at clock edge k gives `fall`=1 during cycle k+2 (through `rx_s1`, `rx_s2`, `rx_d`).
- Let D be the cycle `fall`=1. Then:
  - START is entered at D+1.
  - Data bit n is sampled at cycle D+1+(n+1)·`BAUD_CNT`+`HALF`.
  - The stop bit is sampled at D+1+9·`BAUD_CNT`+`HALF`.
  - `rx_done` or `frame_err` is high at D+2+9·`BAUD_CNT`+`HALF`, for exactly one cycle.
- `busy` rises at D+1. It falls in the same cycle `rx_done`/`frame_err` rises.
- Tolerable baud mismatch is about ±4% (mid-bit sampling, one edge resync per frame).
- No back-pressure. A consumer that misses `rx_done` still sees the byte on `uart_data` until the next good frame.

## Test plan
All scenarios use `CLK_FREQ`=16, `BAUD`=1, giving `BAUD_CNT`=16 and `HALF`=7.
- Reset:
  - Stimulus: hold `rst_n`=0 for 3 cycles with `rx`=1, then release.
  - Required: `uart_data`=8'h00, `rx_done`=0, `frame_err`=0, `busy`=0; no strobe for 200 cycles of idle line.
- Single byte:
  - Stimulus: send 8'hA5 (line sequence 0,1,0,1,0,0,1,0,1,1, 16 cycles per bit).
  - Required: one `rx_done` pulse, 1 cycle wide, at D+153. `uart_data`=8'hA5 from that cycle on. Display path shows "A5".
- Back-to-back:
  - Stimulus: 8'h3C immediately followed by 8'hFF, with the next start bit beginning right after the 16-cycle stop bit.
  - Required: two `rx_done` pulses, 160 cycles apart. `uart_data` reads 8'h3C, then 8'hFF.
- Glitch and framing error:
  - Stimulus 1: a 4-cycle low pulse on the idle line. Required: `busy` high for about 8 cycles, then IDLE; no `rx_done`, no `frame_err`.
  - Stimulus 2: 8'h12 sent with the stop bit held low. Required: `frame_err` pulses once at D+153, `rx_done` stays 0, `uart_data` keeps its previous value; no new frame starts until `rx` returns high.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 for 1 cycle during data bit 4 of 8'h77, then send a clean 8'h81.
  - Required: no strobe for the aborted frame, `uart_data`=8'h00 after the reset, then `uart_data`=8'h81 with a single `rx_done`.
